// File: rtl/data_cache.sv
// data_cache
//   Direct-mapped, write-back, write-allocate data cache: 4 lines x 4 words.
//   Hits complete with zero wait states. Misses run a small FSM that
//   optionally writes the dirty victim back and then fills the line from
//   backing memory. The access then completes as a hit in the next IDLE cycle.
//
// Ports
//   clk, reset             : clock, synchronous active-high reset
//   cpu_read, cpu_write    : CPU request, held until cache_stall drops
//                            (both high counts as a write)
//   cpu_address, cpu_wdata : CPU word address / write data
//   cpu_rdata              : read data, valid with a request and !cache_stall
//   cache_stall            : request cannot complete this cycle
//   mem_read, mem_write    : line fill / line writeback request
//   mem_address            : line-aligned memory word address
//   mem_wdata, mem_rdata   : 4-word line, word 0 in the low bits
//   mem_ack                : one-cycle completion pulse from memory
//   access_count           : completed CPU accesses (wraps)
//   miss_count             : detected misses (wraps)
module data_cache #(
  parameter int WORD_SIZE = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_read,
  input  logic                   cpu_write,
  input  logic [WORD_SIZE-1:0]   cpu_address,
  input  logic [WORD_SIZE-1:0]   cpu_wdata,
  output logic [WORD_SIZE-1:0]   cpu_rdata,
  output logic                   cache_stall,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [WORD_SIZE-1:0]   mem_address,
  output logic [4*WORD_SIZE-1:0] mem_wdata,
  input  logic [4*WORD_SIZE-1:0] mem_rdata,
  input  logic                   mem_ack,
  output logic [15:0]            access_count,
  output logic [15:0]            miss_count
);

  localparam int TAG_W = WORD_SIZE - 4;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  state_t state, state_nxt;

  logic [3:0]           valid;
  logic [3:0]           dirty;
  logic [TAG_W-1:0]     tags [4];
  logic [WORD_SIZE-1:0] data [4][4];

  // Address captured at miss detection; the CPU address is ignored while
  // the miss is being serviced.
  logic [WORD_SIZE-1:0] miss_addr;

  logic             req;
  logic [1:0]       idx;
  logic [1:0]       off;
  logic [TAG_W-1:0] tag;
  logic             hit;
  logic [1:0]       m_idx;
  logic [TAG_W-1:0] m_tag;
  logic             wr_hit;
  logic             miss_det;
  logic             fill_done;

  assign req   = cpu_read | cpu_write;
  assign idx   = cpu_address[3:2];
  assign off   = cpu_address[1:0];
  assign tag   = cpu_address[WORD_SIZE-1:4];
  assign hit   = valid[idx] && (tags[idx] == tag);
  assign m_idx = miss_addr[3:2];
  assign m_tag = miss_addr[WORD_SIZE-1:4];

  // Storage write enables. Gated by reset so that a reset landing in the
  // middle of a transaction leaves the line untouched.
  assign wr_hit    = !reset && (state == IDLE) && req && hit && cpu_write;
  assign miss_det  = !reset && (state == IDLE) && req && !hit;
  assign fill_done = !reset && (state == ALLOCATE) && mem_ack;

  // Next state and outputs. All outputs are forced to zero while reset is
  // high, even though the state register only clears at the edge.
  always_comb begin
    state_nxt   = state;
    cache_stall = 1'b0;
    cpu_rdata   = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    if (!reset) begin
      unique case (state)
        IDLE: begin
          if (req) begin
            if (hit) begin
              cpu_rdata = data[idx][off];
            end else begin
              cache_stall = 1'b1;
              state_nxt   = (valid[idx] && dirty[idx]) ? WRITEBACK : ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          cache_stall = 1'b1;
          mem_write   = 1'b1;
          mem_address = {tags[m_idx], m_idx, 2'b00};
          mem_wdata   = {data[m_idx][3], data[m_idx][2],
                         data[m_idx][1], data[m_idx][0]};
          if (mem_ack) state_nxt = ALLOCATE;
        end
        ALLOCATE: begin
          cache_stall = 1'b1;
          mem_read    = 1'b1;
          mem_address = {m_tag, m_idx, 2'b00};
          if (mem_ack) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Control state: FSM, line status bits, counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      valid        <= '0;
      dirty        <= '0;
      access_count <= '0;
      miss_count   <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && req && hit) access_count <= access_count + 16'd1;
      if (miss_det) miss_count <= miss_count + 16'd1;
      if (wr_hit) dirty[idx] <= 1'b1;
      if ((state == WRITEBACK) && mem_ack) dirty[m_idx] <= 1'b0;
      if (fill_done) begin
        valid[m_idx] <= 1'b1;
        dirty[m_idx] <= 1'b0;
      end
    end
  end

  // Tag/data storage and the latched miss address carry no reset.
  always_ff @(posedge clk) begin
    if (miss_det) miss_addr <= cpu_address;
    if (wr_hit) data[idx][off] <= cpu_wdata;
    if (fill_done) begin
      tags[m_idx] <= m_tag;
      for (int w = 0; w < 4; w++) begin
        data[m_idx][w] <= mem_rdata[w*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache
//   Self-checking bench for data_cache. A flat word-addressed reference
//   memory (refm) holds what every CPU read must return; a backing memory
//   model (backing) answers fills and absorbs writebacks. Expected read data
//   is queued when a read is driven and popped when the cache completes it.
module tb_data_cache;

  localparam int LAT = 3;  // mem_ack arrives in the 3rd cycle of a request

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_read, cpu_write;
  logic [15:0] cpu_address, cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cache_stall, mem_read, mem_write;
  logic [15:0] mem_address;
  logic [63:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [15:0] access_count, miss_count;

  data_cache #(.WORD_SIZE(16)) dut (
    .clk(clk), .reset(reset),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_address(cpu_address), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cache_stall(cache_stall),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .access_count(access_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] backing [int];
  logic [63:0] refm    [int];
  logic [15:0] exp_q   [$];

  logic        auto_ack  = 1'b1;
  logic        force_ack = 1'b0;
  logic [15:0] last_fill_addr = '0;
  logic [15:0] last_wb_addr   = '0;
  logic [63:0] last_wb_data   = '0;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] default_line(input logic [13:0] la);
    logic [63:0] l;
    for (int w = 0; w < 4; w++) l[w*16 +: 16] = {la, w[1:0]} ^ 16'hC3C3;
    return l;
  endfunction

  function automatic logic [63:0] backing_line(input logic [13:0] la);
    if (backing.exists(int'(la))) return backing[int'(la)];
    return default_line(la);
  endfunction

  function automatic logic [63:0] ref_line(input logic [13:0] la);
    if (refm.exists(int'(la))) return refm[int'(la)];
    return default_line(la);
  endfunction

  // Backing memory responder.
  initial begin
    int cnt = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = force_ack;
      if (force_ack) mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      if (auto_ack && (mem_read || mem_write)) begin
        cnt++;
        if (cnt == LAT) begin
          cnt     = 0;
          mem_ack = 1'b1;
          check_eq("mem_rw_exclusive", {63'd0, mem_read & mem_write}, 64'd0);
          check_eq("mem_addr_align", {62'd0, mem_address[1:0]}, 64'd0);
          if (mem_write) begin
            last_wb_addr = mem_address;
            last_wb_data = mem_wdata;
            check_eq("wb_data_vs_ref", mem_wdata, ref_line(mem_address[15:2]));
            backing[int'(mem_address[15:2])] = mem_wdata;
          end else begin
            last_fill_addr = mem_address;
            mem_rdata = backing_line(mem_address[15:2]);
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // One CPU access, held until the cache stops stalling.
  task automatic cpu_access(input logic rd, input logic wr,
                            input logic [15:0] a, input logic [15:0] d,
                            output int stalls);
    logic        done;
    logic [63:0] l;
    logic [15:0] exp;
    @(posedge clk); #1;
    cpu_read = rd; cpu_write = wr; cpu_address = a; cpu_wdata = d;
    if (wr) begin
      l = ref_line(a[15:2]);
      l[a[1:0]*16 +: 16] = d;
      refm[int'(a[15:2])] = l;
    end else begin
      l = ref_line(a[15:2]);
      exp_q.push_back(l[a[1:0]*16 +: 16]);
    end
    stalls = 0;
    done   = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!cache_stall) begin
        done = 1'b1;
        break;
      end
      stalls++;
    end
    check_eq("access_done", {63'd0, done}, 64'd1);
    if (!wr && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      if (done) check_eq("rdata", {48'd0, cpu_rdata}, {48'd0, exp});
    end
    @(posedge clk); #1;
    cpu_read = 1'b0; cpu_write = 1'b0;
  endtask

  initial begin
    int st;
    reset = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0;
    cpu_address = '0; cpu_wdata = '0;
    backing[int'(14'h0004)] = 64'h4444_3333_2222_1111;
    refm = backing;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_stall", {63'd0, cache_stall}, 64'd0);
    check_eq("rst_mem_rw", {62'd0, mem_read, mem_write}, 64'd0);
    check_eq("rst_mem_addr", {48'd0, mem_address}, 64'd0);
    check_eq("rst_mem_wdata", mem_wdata, 64'd0);
    check_eq("rst_rdata", {48'd0, cpu_rdata}, 64'd0);
    check_eq("rst_counts", {32'd0, access_count, miss_count}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Cold read, clean victim.
    cpu_access(1'b1, 1'b0, 16'h0012, 16'h0, st);
    check_eq("cold_stalls", st, 4);
    check_eq("cold_fill_addr", {48'd0, last_fill_addr}, 64'h0010);
    check_eq("cold_counts", {32'd0, access_count, miss_count}, {32'd0, 16'd1, 16'd1});

    // Hit in the same line.
    cpu_access(1'b1, 1'b0, 16'h0013, 16'h0, st);
    check_eq("hit_stalls", st, 0);
    check_eq("hit_access", {48'd0, access_count}, 64'd2);

    // Stray mem_ack while idle must be ignored.
    @(posedge clk); #1; force_ack = 1'b1;
    @(posedge clk); #1; force_ack = 1'b0;
    @(negedge clk);
    check_eq("idle_ack_stall", {63'd0, cache_stall}, 64'd0);
    cpu_access(1'b1, 1'b0, 16'h0013, 16'h0, st);
    check_eq("idle_ack_hit", st, 0);

    // Write hit, then conflicting read forces a writeback.
    cpu_access(1'b0, 1'b1, 16'h0011, 16'hABCD, st);
    check_eq("wr_hit_stalls", st, 0);
    cpu_access(1'b1, 1'b0, 16'h0051, 16'h0, st);
    check_eq("dirty_stalls", st, 7);
    check_eq("wb_addr", {48'd0, last_wb_addr}, 64'h0010);
    check_eq("wb_data", last_wb_data, 64'h4444_3333_ABCD_1111);
    check_eq("dirty_fill_addr", {48'd0, last_fill_addr}, 64'h0050);
    check_eq("dirty_miss", {48'd0, miss_count}, 64'd2);

    // Read and write together behaves as a write.
    cpu_access(1'b1, 1'b1, 16'h0012, 16'h5A5A, st);
    check_eq("rw_stalls", st, 4);
    cpu_access(1'b1, 1'b0, 16'h0012, 16'h0, st);
    check_eq("rw_readback_stalls", st, 0);

    // Write miss to a dirty index: writeback then allocate then write.
    cpu_access(1'b0, 1'b1, 16'h0053, 16'h7777, st);
    check_eq("wr_miss_stalls", st, 7);
    check_eq("pre_rst_counts", {32'd0, access_count, miss_count}, {32'd0, 16'd8, 16'd4});

    // Reset in the middle of a fill, followed by a late ack.
    auto_ack = 1'b0;
    @(posedge clk); #1;
    cpu_read = 1'b1; cpu_address = 16'h0105;
    @(negedge clk);
    @(negedge clk);
    check_eq("alloc_mem_read", {63'd0, mem_read}, 64'd1);
    check_eq("alloc_addr", {48'd0, mem_address}, 64'h0104);
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    check_eq("rst_alloc_mem_read", {63'd0, mem_read}, 64'd0);
    check_eq("rst_alloc_stall", {63'd0, cache_stall}, 64'd0);
    check_eq("rst_alloc_addr", {48'd0, mem_address}, 64'd0);
    @(posedge clk); #1; reset = 1'b0; cpu_read = 1'b0; force_ack = 1'b1;
    @(posedge clk); #1; force_ack = 1'b0; auto_ack = 1'b1;
    @(negedge clk);
    check_eq("late_ack_mem_read", {63'd0, mem_read}, 64'd0);
    check_eq("late_ack_counts", {32'd0, access_count, miss_count}, 64'd0);
    refm = backing;  // dirty data in the cache was lost with the reset
    cpu_access(1'b1, 1'b0, 16'h0105, 16'h0, st);
    check_eq("post_rst_miss_stalls", st, 4);
    cpu_access(1'b1, 1'b0, 16'h0053, 16'h0, st);
    check_eq("post_rst_dirty_lost_stalls", st, 4);
    check_eq("post_rst_counts", {32'd0, access_count, miss_count}, {32'd0, 16'd2, 16'd2});

    // Request dropped during the fill.
    @(posedge clk); #1;
    cpu_read = 1'b1; cpu_address = 16'h0209;
    for (int i = 0; i < 10 && !mem_read; i++) @(negedge clk);
    check_eq("drop_alloc_seen", {63'd0, mem_read}, 64'd1);
    @(posedge clk); #1; cpu_read = 1'b0;
    for (int i = 0; i < 20 && mem_read; i++) @(negedge clk);
    check_eq("drop_fill_done", {63'd0, mem_read}, 64'd0);
    @(negedge clk);
    check_eq("drop_stall", {63'd0, cache_stall}, 64'd0);
    check_eq("drop_counts", {32'd0, access_count, miss_count}, {32'd0, 16'd2, 16'd3});
    check_eq("drop_fill_addr", {48'd0, last_fill_addr}, 64'h0208);
    cpu_access(1'b1, 1'b0, 16'h0209, 16'h0, st);
    check_eq("drop_later_hit", st, 0);
    check_eq("drop_final_access", {48'd0, access_count}, 64'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
